// File: rtl/clk_div_pkg.sv
// Shared constants, mode encoding and low-phase length helper for the clock divider.
package clk_div_pkg;

    localparam int MIN_DIV = 2;

    typedef enum logic {
        MODE_DUTY  = 1'b0,
        MODE_PULSE = 1'b1
    } mode_t;

    // Duty mode keeps the extra cycle of an odd ratio in the low phase.
    function automatic logic [31:0] low_phase_len(input logic [31:0] n, input mode_t mode);
        if (mode == MODE_PULSE) begin
            return n - 32'd1;
        end
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/clk_div_gen_if.sv
// Control and output bundle of the clock divider; the clock consumer side is the master.
interface clk_div_gen_if #(
    parameter int DIV_WIDTH = 8
);
    logic                 CLK_EN;
    logic [DIV_WIDTH-1:0] Div;
    logic                 Pulse_Mode;
    logic                 CLK_Div_Out;
    logic                 Tick;
    logic [DIV_WIDTH-1:0] Active_Div;
    logic                 Bypass;

    modport master (
        output CLK_EN, Div, Pulse_Mode,
        input  CLK_Div_Out, Tick, Active_Div, Bypass
    );

    modport slave (
        input  CLK_EN, Div, Pulse_Mode,
        output CLK_Div_Out, Tick, Active_Div, Bypass
    );
endinterface

// File: rtl/clk_div_phase.sv
// Period arithmetic for the divider: low-phase length plus the wrap and next-cycle compares.
module clk_div_phase
    import clk_div_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic [DIV_WIDTH-1:0] n,
    input  mode_t                mode,
    input  logic [DIV_WIDTH-1:0] count,
    output logic [DIV_WIDTH-1:0] low_len,
    output logic                 wrap,
    output logic                 next_high,
    output logic                 next_tick
);
    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] next_count;

    // next_count is only consumed off the wrap cycle, where count+1 <= N-1 cannot overflow.
    assign low_len    = DIV_WIDTH'(low_phase_len(32'(n), mode));
    assign wrap       = (count == n - ONE);
    assign next_count = count + ONE;
    assign next_high  = (next_count >= low_len);
    assign next_tick  = (next_count == low_len);

endmodule

// File: rtl/clk_div_gen.sv
// Runtime-ratio clock divider with pulse mode, tick strobe and boundary-aligned ratio/bypass changes.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic          CLK_Ref,
    input  logic          Reset,
    clk_div_gen_if.slave  bus
);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(MIN_DIV);

    logic [DIV_WIDTH-1:0] count;
    logic [DIV_WIDTH-1:0] active_div;
    logic [DIV_WIDTH-1:0] low_len;
    mode_t                mode;
    logic                 div_q;
    logic                 tick;
    logic                 bypass;
    logic                 req_ok;
    logic                 wrap;
    logic                 next_high;
    logic                 next_tick;

    assign req_ok = bus.CLK_EN && (bus.Div >= DIV_MIN);

    clk_div_phase #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_phase (
        .n         (active_div),
        .mode      (mode),
        .count     (count),
        .low_len   (low_len),
        .wrap      (wrap),
        .next_high (next_high),
        .next_tick (next_tick)
    );

    // Ratio, mode and bypass only change on a wrap edge (or when leaving bypass), so every
    // started period runs to completion and the switch to CLK_Ref happens with div_q low.
    always_ff @(posedge CLK_Ref) begin
        if (Reset) begin
            count      <= '0;
            div_q      <= 1'b0;
            tick       <= 1'b0;
            bypass     <= 1'b1;
            active_div <= '0;
            mode       <= MODE_DUTY;
        end else if (bypass) begin
            tick <= 1'b0;
            if (req_ok) begin
                bypass     <= 1'b0;
                active_div <= bus.Div;
                mode       <= mode_t'(bus.Pulse_Mode);
                count      <= '0;
                div_q      <= 1'b0;
            end
        end else if (wrap) begin
            count <= '0;
            div_q <= 1'b0;
            tick  <= 1'b0;
            if (req_ok) begin
                active_div <= bus.Div;
                mode       <= mode_t'(bus.Pulse_Mode);
            end else begin
                bypass     <= 1'b1;
                active_div <= '0;
            end
        end else begin
            count <= count + ONE;
            div_q <= next_high;
            tick  <= next_tick;
        end
    end

    assign bus.CLK_Div_Out = bypass ? CLK_Ref : div_q;
    assign bus.Tick        = tick;
    assign bus.Active_Div  = active_div;
    assign bus.Bypass      = bypass;

    // Low-phase length is only needed by the compares inside the phase block.
    logic unused_low_len;
    assign unused_low_len = ^low_len;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen against a period-at-a-time waveform model.
module tb_clk_div_gen;

    localparam int W = 8;

    typedef struct packed {
        logic high;
        logic tick;
    } slot_t;

    logic clk_ref = 1'b0;
    logic reset   = 1'b1;

    clk_div_gen_if #(.DIV_WIDTH(W)) bus ();

    clk_div_gen #(
        .DIV_WIDTH (W)
    ) dut (
        .CLK_Ref (clk_ref),
        .Reset   (reset),
        .bus     (bus)
    );

    always #5 clk_ref = ~clk_ref;

    slot_t period_q[$];
    bit    m_bypass = 1'b1;
    int    m_active = 0;
    int    tests    = 0;
    int    fails    = 0;

    // Expected waveform of one whole period, laid out from the low/high phase lengths.
    function automatic void buildPeriod(input int n, input bit pulse);
        int lows;
        lows = pulse ? n - 1 : (n + 1) / 2;
        for (int k = 0; k < n; k++) begin
            period_q.push_back('{high: (k >= lows), tick: (k == lows)});
        end
    endfunction

    function automatic void modelEdge();
        bit req_ok;
        req_ok = (bus.CLK_EN === 1'b1) && (int'(bus.Div) >= 2);
        if (reset) begin
            m_bypass = 1'b1;
            m_active = 0;
            period_q.delete();
        end else if (m_bypass) begin
            if (req_ok) begin
                m_bypass = 1'b0;
                m_active = int'(bus.Div);
                buildPeriod(m_active, bus.Pulse_Mode);
            end
        end else begin
            void'(period_q.pop_front());
            if (period_q.size() == 0) begin
                if (req_ok) begin
                    m_active = int'(bus.Div);
                    buildPeriod(m_active, bus.Pulse_Mode);
                end else begin
                    m_bypass = 1'b1;
                    m_active = 0;
                end
            end
        end
    endfunction

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic exp_out;
        logic exp_tick;
        exp_out  = m_bypass ? 1'b1 : period_q[0].high;
        exp_tick = m_bypass ? 1'b0 : period_q[0].tick;
        compare("bypass",     32'(bus.Bypass),      32'(m_bypass));
        compare("active_div", 32'(bus.Active_Div),  32'(m_active));
        compare("tick",       32'(bus.Tick),        32'(exp_tick));
        compare("clk_out",    32'(bus.CLK_Div_Out), 32'(exp_out));
    endtask

    task automatic applyStimulus(input logic en, input int div, input logic pm, input logic rst);
        bus.CLK_EN     = en;
        bus.Div        = W'(div);
        bus.Pulse_Mode = pm;
        reset          = rst;
    endtask

    // In bypass the output must also follow CLK_Ref low, not just high.
    task automatic stepCycle();
        modelEdge();
        @(posedge clk_ref);
        #1;
        checkOutput();
        @(negedge clk_ref);
        #1;
        if (m_bypass) compare("bypass_low", 32'(bus.CLK_Div_Out), 32'd0);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic runUntilCount(input int k);
        int guard;
        guard = 0;
        while (m_bypass || (m_active - period_q.size()) != k) begin
            if (guard >= 600) begin
                tests++;
                fails++;
                $error("[TB] FAIL count_wait: observed timeout expected count %0d", k);
                break;
            end
            stepCycle();
            guard++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        runCycles(3);

        applyStimulus(1'b1, 4, 1'b0, 1'b0);
        runCycles(13);

        applyStimulus(1'b1, 5, 1'b0, 1'b0);
        runCycles(15);

        applyStimulus(1'b1, 255, 1'b0, 1'b0);
        runCycles(520);

        applyStimulus(1'b1, 6, 1'b0, 1'b0);
        runUntilCount(0);
        runUntilCount(1);
        applyStimulus(1'b1, 3, 1'b0, 1'b0);
        runCycles(12);

        applyStimulus(1'b1, 3, 1'b1, 1'b0);
        runCycles(10);

        applyStimulus(1'b1, 8, 1'b0, 1'b0);
        runUntilCount(0);
        runUntilCount(5);
        applyStimulus(1'b0, 8, 1'b0, 1'b0);
        runCycles(6);

        applyStimulus(1'b1, 8, 1'b0, 1'b0);
        runUntilCount(5);
        applyStimulus(1'b1, 1, 1'b0, 1'b0);
        runCycles(6);

        applyStimulus(1'b1, 8, 1'b0, 1'b0);
        runUntilCount(5);
        applyStimulus(1'b1, 0, 1'b0, 1'b0);
        runCycles(6);

        applyStimulus(1'b1, 6, 1'b0, 1'b0);
        runUntilCount(3);
        applyStimulus(1'b1, 6, 1'b0, 1'b1);
        runCycles(1);
        applyStimulus(1'b1, 6, 1'b0, 1'b0);
        runCycles(10);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                applyStimulus(
                    ($urandom_range(0, 5) != 0),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 9)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 39) == 0));
            end else begin
                reset = 1'b0;
            end
            stepCycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
